mod_acc_frm: RTL

- Transmitter side of the mod_acc list interface.
- Takes list commands (length + side) and operands through valid/ready handshakes.
- Emits the avail/sol/eol/side framed stream that mod_acc consumes; each operand is reduced into [0, MOD_M).
- Sits between operand producers (memory readers, NTT outputs) and one mod_acc instance.

---
 rtl/mod_acc_frm_pkg.sv | 28 ++
 rtl/mod_acc_frm_cmd_fifo.sv | 47 ++++
 rtl/mod_acc_frm.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mod_acc_frm_pkg.sv
// Shared types and constants for the mod_acc list-framing transmitter.
// Widths and modulus for every file in this block are defined here.
package mod_acc_frm_pkg;

  localparam int OP_W      = 33;
  localparam int SIDE_W    = 8;
  localparam int LEN_W     = 4;
  localparam int CMD_DEPTH = 4;

  // 2**OP_W - 2**(OP_W/2) + 1; must exceed 2**(OP_W-1) so one subtract reduces any operand
  localparam logic [OP_W-1:0] MOD_M =
    OP_W'((64'd1 << OP_W) - (64'd1 << (OP_W / 2)) + 64'd1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } frm_state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [SIDE_W-1:0] side;
  } frm_cmd_t;

  function automatic logic [OP_W-1:0] mod_reduce(input logic [OP_W-1:0] op);
    return (op >= MOD_M) ? op - MOD_M : op;
  endfunction

endpackage

// File: rtl/mod_acc_frm_cmd_fifo.sv
// Synchronous command FIFO with head read; no write bypass, so a full FIFO
// refuses a push even when a pop happens in the same cycle.
module mod_acc_frm_cmd_fifo
  import mod_acc_frm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  frm_cmd_t push_cmd,
  input  logic     pop,
  output frm_cmd_t head,
  output logic     empty,
  output logic     full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  frm_cmd_t    mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_cmd;
  end

endmodule

// File: rtl/mod_acc_frm.sv
// Frames operands into the avail/sol/eol/side list stream consumed by mod_acc.
// Optional macro MOD_ACC_FRM_STATS_EN adds the stat_list_cnt completed-list counter.
module mod_acc_frm
  import mod_acc_frm_pkg::*;
(
  input  logic              clk,
  input  logic              a_rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [SIDE_W-1:0] cmd_side,
  input  logic              data_vld,
  output logic              data_rdy,
  input  logic [OP_W-1:0]   data_op,
  output logic              out_avail,
  output logic [OP_W-1:0]   out_op,
  output logic              out_sol,
  output logic              out_eol,
  output logic [SIDE_W-1:0] out_side,
  output logic              busy,
`ifdef MOD_ACC_FRM_STATS_EN
  output logic [31:0]       stat_list_cnt,
`endif
  output logic              err_len0
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
  // ready never depends on valid, and a producer may hold valid high across stalls.

  frm_state_e        state, state_nxt;
  frm_cmd_t          head;
  logic              empty, full;
  logic              cmd_pop, load, set_err, accept, last;
  logic [LEN_W-1:0]  cur_len;
  logic [SIDE_W-1:0] cur_side;
  logic [LEN_W-1:0]  cnt;

  mod_acc_frm_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk      (clk),
    .rst      (a_rst),
    .push     (cmd_vld),
    .push_cmd ('{len: cmd_len, side: cmd_side}),
    .pop      (cmd_pop),
    .head     (head),
    .empty    (empty),
    .full     (full)
  );

  assign cmd_rdy  = !full;
  assign data_rdy = (state == SEND);
  assign busy     = (state == SEND) || !empty;

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    load      = 1'b0;
    set_err   = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          cmd_pop = 1'b1;
          if (head.len == '0) begin
            set_err = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        accept = data_vld;
        last   = (cnt == cur_len - LEN_W'(1));
        // Chain straight into the next queued list so back-to-back lists have no bubble
        if (accept && last) begin
          if (!empty) begin
            cmd_pop = 1'b1;
            if (head.len == '0) begin
              set_err   = 1'b1;
              state_nxt = IDLE;
            end else begin
              load = 1'b1;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state    <= IDLE;
      cur_len  <= '0;
      cur_side <= '0;
      cnt      <= '0;
      err_len0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cur_len  <= head.len;
        cur_side <= head.side;
        cnt      <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
      if (set_err) err_len0 <= 1'b1;
    end
  end

  // Output register: payload fields hold their last value when nothing is accepted
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      out_avail <= 1'b0;
      out_op    <= '0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      out_side  <= '0;
    end else begin
      out_avail <= accept;
      if (accept) begin
        out_op   <= mod_reduce(data_op);
        out_sol  <= (cnt == '0);
        out_eol  <= last;
        out_side <= cur_side;
      end
    end
  end

`ifdef MOD_ACC_FRM_STATS_EN
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      stat_list_cnt <= '0;
    end else if (out_avail && out_eol) begin
      stat_list_cnt <= stat_list_cnt + 32'd1;
    end
  end
`endif

endmodule
